// File: rtl/perf_counter_unit.sv
// Cycle, instret and NCNT event counters with inhibit/event CSRs.
// CSR accesses from EM return the pre-update value one cycle later.
module perf_counter_unit #(
  parameter int NCNT = 4,
  parameter int CW   = 64,
  parameter int EVW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            retire,
  input  logic [EVW-1:0]  ev,
  input  logic            csr_en,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [31:0]     csr_wdata,
  output logic [31:0]     rd_data,
  output logic            rd_valid,
  output logic            rd_illegal
);
  localparam int NC = NCNT + 3;

  // Index 1 is a constant-zero slot with no CSR address.
  logic [CW-1:0]   cnt_reg  [NC];
  logic [CW-1:0]   cnt_next [NC];
  logic [EVW-1:0]  evt_reg  [3:NCNT+2];
  logic [NC-1:0]   inh_reg;
  logic [NC-1:0]   inc_vec;
  logic [31:0]     inh32;
  logic [31:0]     rd_data_reg;
  logic            rd_valid_reg;
  logic            rd_illegal_reg;

  logic [4:0]  idx;
  logic        is_cnt_lo, is_cnt_hi, is_csr3, idx_hpm, idx_cnt_ok;
  logic        sel_cnt, sel_inh, sel_evt, mapped, read_only;
  logic        wants_write, illegal, wr_en;
  logic [31:0] old_val, new_val;

  assign inh32      = 32'(inh_reg);
  assign idx        = csr_addr[4:0];
  assign is_cnt_lo  = (csr_addr[11:8] == 4'hC || csr_addr[11:8] == 4'hB) && csr_addr[7:5] == 3'b000;
  assign is_cnt_hi  = (csr_addr[11:8] == 4'hC || csr_addr[11:8] == 4'hB) && csr_addr[7:5] == 3'b100;
  assign is_csr3    = csr_addr[11:5] == 7'b0011001;
  assign idx_hpm    = idx >= 5'd3 && idx <= 5'(NCNT + 2);
  assign idx_cnt_ok = idx == 5'd0 || idx == 5'd2 || idx_hpm;
  assign sel_cnt    = (is_cnt_lo || is_cnt_hi) && idx_cnt_ok;
  assign sel_inh    = is_csr3 && idx == 5'd0;
  assign sel_evt    = is_csr3 && idx_hpm;
  assign mapped     = sel_cnt || sel_inh || sel_evt;
  assign read_only  = csr_addr[11:8] == 4'hC;

  // Set/clear with a zero operand is a pure read, so it is legal on Cxx.
  assign wants_write = csr_op == 2'b01 || (csr_op[1] && |csr_wdata);
  assign illegal     = !mapped || (wants_write && read_only);
  assign wr_en       = csr_en && !illegal && wants_write;

  always_comb begin
    old_val = '0;
    if (sel_cnt) begin
      for (int i = 0; i < NC; i++) begin
        if (idx == 5'(i))
          old_val = is_cnt_hi ? 32'(cnt_reg[i][CW-1:32]) : cnt_reg[i][31:0];
      end
    end
    if (sel_inh)
      old_val = inh32;
    if (sel_evt) begin
      for (int i = 3; i <= NCNT + 2; i++) begin
        if (idx == 5'(i))
          old_val = 32'(evt_reg[i]);
      end
    end
  end

  always_comb begin
    case (csr_op)
      2'b01:   new_val = csr_wdata;
      2'b10:   new_val = old_val | csr_wdata;
      2'b11:   new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
  end

  for (genvar gi = 0; gi < NC; gi++) begin : g_cnt
    if (gi == 1) begin : g_none
      assign inc_vec[gi]  = 1'b0;
      assign cnt_next[gi] = '0;
    end else begin : g_live
      logic wr_this;
      if (gi == 0) begin : g_cycle
        assign inc_vec[gi] = !inh_reg[gi];
      end else if (gi == 2) begin : g_instret
        assign inc_vec[gi] = retire && !inh_reg[gi];
      end else begin : g_hpm
        assign inc_vec[gi] = |(ev & evt_reg[gi]) && !inh_reg[gi];
      end
      assign wr_this = wr_en && sel_cnt && idx == 5'(gi);
      // A full-width add carries low into high in the same cycle; writes win.
      assign cnt_next[gi] = !wr_this ? cnt_reg[gi] + CW'(inc_vec[gi]) :
                            is_cnt_hi ? {new_val[CW-33:0], cnt_reg[gi][31:0]} :
                                        {cnt_reg[gi][CW-1:32], new_val};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) cnt_reg[i] <= '0;
      for (int i = 3; i <= NCNT + 2; i++) evt_reg[i] <= '0;
      inh_reg        <= '0;
      rd_data_reg    <= '0;
      rd_valid_reg   <= 1'b0;
      rd_illegal_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NC; i++) cnt_reg[i] <= cnt_next[i];
      if (wr_en && sel_evt) begin
        for (int i = 3; i <= NCNT + 2; i++) begin
          if (idx == 5'(i)) evt_reg[i] <= new_val[EVW-1:0];
        end
      end
      if (wr_en && sel_inh)
        inh_reg <= {new_val[NC-1:2], 1'b0, new_val[0]};
      rd_data_reg    <= (csr_en && !illegal) ? old_val : 32'd0;
      rd_valid_reg   <= csr_en;
      rd_illegal_reg <= csr_en && illegal;
    end
  end

  assign rd_data    = rd_data_reg;
  assign rd_valid   = rd_valid_reg;
  assign rd_illegal = rd_illegal_reg;
endmodule
